// File: rtl/vga_sync_decoder_pkg.sv
// Shared timing defaults, counter width and receiver FSM encoding for the VGA sync decoder.
// Consumers: sync_edge_detect and vga_sync_decoder (optional macro VGA_RX_SYNC2_EN).
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int HPIXELS_DEF = 800;
    localparam int VLINES_DEF  = 525;
    localparam int HPULSE_DEF  = 96;
    localparam int VPULSE_DEF  = 2;
    localparam int HBP_DEF     = 144;
    localparam int HFP_DEF     = 784;
    localparam int VBP_DEF     = 35;
    localparam int VFP_DEF     = 515;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_e;

    // Counters stick at all-ones so a missing hsync is visible as a timeout.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_sync_decoder_sync_edge_detect.sv
// Per-signal front end: optional two-flop synchronizer (VGA_RX_SYNC2_EN), previous-sample
// register and fall/rise pulses on the sampled level.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall,
    output logic rise
);

    logic prev_q;
    logic prev_d;

`ifdef VGA_RX_SYNC2_EN
    logic s1_q;
    logic s1_d;
    logic s2_q;
    logic s2_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
    end

    // Reset to the idle (high) level so no edge is reported after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign level = s2_q;
`else
    assign level = din;
`endif

    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign fall = prev_q & ~level;
    assign rise = ~prev_q & level;

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds hc/vc from active-low hsync/vsync, verifies every line and frame, and reports lock,
// display enable and active-pixel coordinates. Optional macro: VGA_RX_SYNC2_EN.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int HPIXELS = HPIXELS_DEF,
    parameter int VLINES  = VLINES_DEF,
    parameter int HPULSE  = HPULSE_DEF,
    parameter int VPULSE  = VPULSE_DEF,
    parameter int HBP     = HBP_DEF,
    parameter int HFP     = HFP_DEF,
    parameter int VBP     = VBP_DEF,
    parameter int VFP     = VFP_DEF
) (
    input  logic             dclk,
    input  logic             clr_n,
    input  logic             hsync,
    input  logic             vsync,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             locked,
    output logic             de,
    output logic [CNT_W-1:0] px_x,
    output logic [CNT_W-1:0] px_y,
    output logic             frame_start,
    output logic             err
);

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(HPIXELS - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(VLINES - 1);
    localparam logic [CNT_W-1:0] H_PW_LAST = CNT_W'(HPULSE - 1);
    localparam logic [CNT_W-1:0] V_PW_LAST = CNT_W'(VPULSE - 1);
    localparam logic [CNT_W-1:0] H_BP      = CNT_W'(HBP);
    localparam logic [CNT_W-1:0] H_FP      = CNT_W'(HFP);
    localparam logic [CNT_W-1:0] V_BP      = CNT_W'(VBP);
    localparam logic [CNT_W-1:0] V_FP      = CNT_W'(VFP);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic h_level;
    logic hfall;
    logic hrise;
    logic v_level;
    logic vfall;
    logic vrise;
    logic [1:0] unused_levels;

    sync_edge_detect u_hsync_edge (
        .clk   (dclk),
        .rst_n (clr_n),
        .din   (hsync),
        .level (h_level),
        .fall  (hfall),
        .rise  (hrise)
    );

    sync_edge_detect u_vsync_edge (
        .clk   (dclk),
        .rst_n (clr_n),
        .din   (vsync),
        .level (v_level),
        .fall  (vfall),
        .rise  (vrise)
    );

    assign unused_levels = {h_level, v_level};

    logic [CNT_W-1:0] hc_q;
    logic [CNT_W-1:0] hc_d;
    logic [CNT_W-1:0] vc_q;
    logic [CNT_W-1:0] vc_d;
    rx_state_e        state_q;
    rx_state_e        state_d;
    logic             locked_q;
    logic             locked_d;
    logic             frame_start_q;
    logic             frame_start_d;
    logic             err_q;
    logic             err_d;
    logic             viol;

    always_comb begin
        hc_d = hfall ? '0 : sat_inc(hc_q);
        vc_d = vc_q;
        if (hfall) begin
            vc_d = vfall ? '0 : sat_inc(vc_q);
        end
    end

    // All checks look at the counters before this cycle's update.
    always_comb begin
        viol = 1'b0;
        if (hfall && (hc_q != H_LAST)) begin
            viol = 1'b1;
        end
        if (hrise && (hc_q != H_PW_LAST)) begin
            viol = 1'b1;
        end
        if (vfall && (!hfall || (vc_q != V_LAST))) begin
            viol = 1'b1;
        end
        if (vrise && (!hfall || (vc_q != V_PW_LAST))) begin
            viol = 1'b1;
        end
        if ((hc_q == CNT_MAX) && !hfall) begin
            viol = 1'b1;
        end
    end

    // A violation always takes priority over a frame boundary in the same cycle.
    always_comb begin
        state_d       = state_q;
        locked_d      = locked_q;
        frame_start_d = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                locked_d = 1'b0;
                if (vfall && hfall) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                locked_d = 1'b0;
                if (viol) begin
                    state_d = ST_SEARCH;
                    err_d   = 1'b1;
                end else if (vfall) begin
                    state_d       = ST_LOCKED;
                    locked_d      = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                locked_d = 1'b1;
                if (viol) begin
                    state_d  = ST_SEARCH;
                    locked_d = 1'b0;
                    err_d    = 1'b1;
                end else if (vfall) begin
                    frame_start_d = 1'b1;
                end
            end
            default: begin
                state_d  = ST_SEARCH;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            hc_q          <= '0;
            vc_q          <= '0;
            state_q       <= ST_SEARCH;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            state_q       <= state_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            err_q         <= err_d;
        end
    end

    logic h_active;
    logic v_active;

    assign h_active    = (hc_q >= H_BP) && (hc_q < H_FP);
    assign v_active    = (vc_q >= V_BP) && (vc_q < V_FP);
    assign de          = locked_q && h_active && v_active;
    assign px_x        = de ? (hc_q - H_BP) : '0;
    assign px_y        = de ? (vc_q - V_BP) : '0;
    assign hc          = hc_q;
    assign vc          = vc_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder driven by a reduced-size transmitter model
// (40x20 timing) so several full frames fit in a short run.
module tb_vga_sync_decoder;

    localparam int HP  = 40;
    localparam int VL  = 20;
    localparam int HPW = 4;
    localparam int VPW = 2;
    localparam int HB  = 8;
    localparam int HF  = 36;
    localparam int VB  = 4;
    localparam int VF  = 18;
`ifdef VGA_RX_SYNC2_EN
    localparam int LAG = 3;
`else
    localparam int LAG = 1;
`endif

    logic       dclk = 1'b0;
    logic       clr_n = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       locked;
    logic       de;
    logic [9:0] px_x;
    logic [9:0] px_y;
    logic       frame_start;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Transmitter model state and per-cycle history of what it drove.
    int tx_hc = 0;
    int tx_vc = 0;
    int cur_len = HP;
    bit stretch_req = 0;
    bit hold_sync = 0;
    bit st_flag = 0;
    int hist_hc[4];
    int hist_vc[4];
    bit hist_fs[4];
    bit hist_st[4];

    vga_sync_decoder #(
        .HPIXELS (HP),
        .VLINES  (VL),
        .HPULSE  (HPW),
        .VPULSE  (VPW),
        .HBP     (HB),
        .HFP     (HF),
        .VBP     (VB),
        .VFP     (VF)
    ) dut (
        .dclk        (dclk),
        .clr_n       (clr_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .hc          (hc),
        .vc          (vc),
        .locked      (locked),
        .de          (de),
        .px_x        (px_x),
        .px_y        (px_y),
        .frame_start (frame_start),
        .err         (err)
    );

    always #5 dclk = ~dclk;

    task automatic drive_sync();
        hsync = hold_sync || (tx_hc >= HPW);
        vsync = hold_sync || (tx_vc >= VPW);
    endtask

    // One dclk: sample 1 time unit after the edge, log what was driven, advance the model.
    task automatic tick();
        @(posedge dclk);
        #1;
        for (int i = 3; i > 0; i--) begin
            hist_hc[i] = hist_hc[i-1];
            hist_vc[i] = hist_vc[i-1];
            hist_fs[i] = hist_fs[i-1];
            hist_st[i] = hist_st[i-1];
        end
        hist_hc[0] = tx_hc;
        hist_vc[0] = tx_vc;
        hist_fs[0] = (tx_hc == 0) && (tx_vc == 0) && !hold_sync;
        hist_st[0] = st_flag;
        st_flag = 0;
        if (tx_hc >= cur_len - 1) begin
            st_flag = (cur_len != HP);
            tx_hc = 0;
            cur_len = HP;
            if (stretch_req) begin
                cur_len = HP + 1;
                stretch_req = 0;
            end
            tx_vc = (tx_vc == VL - 1) ? 0 : tx_vc + 1;
        end else begin
            tx_hc++;
        end
        drive_sync();
    endtask

    task automatic do_reset(input int h0, input int v0);
        clr_n = 1'b0;
        tx_hc = h0;
        tx_vc = v0;
        cur_len = HP;
        stretch_req = 0;
        hold_sync = 0;
        st_flag = 0;
        for (int i = 0; i < 4; i++) begin
            hist_hc[i] = 0;
            hist_vc[i] = 0;
            hist_fs[i] = 0;
            hist_st[i] = 0;
        end
        drive_sync();
        repeat (3) tick();
    endtask

    task automatic wait_pos(input int h, input int v, input string name);
        int n = 0;
        while (!(tx_hc == h && tx_vc == v) && n < 2 * HP * VL) begin
            tick();
            n++;
        end
        checks++;
        if (!(tx_hc == h && tx_vc == v)) begin
            errors++;
            $display("FAIL %s position got=%0d/%0d exp=%0d/%0d", name, tx_hc, tx_vc, h, v);
        end
    endtask

    task automatic test_reset();
        do_reset(10, 7);
        checks += 8;
        if (hc !== 10'd0) begin errors++; $display("FAIL rst_hc got=%0d exp=0", hc); end
        if (vc !== 10'd0) begin errors++; $display("FAIL rst_vc got=%0d exp=0", vc); end
        if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got=%0b exp=0", locked); end
        if (de !== 1'b0) begin errors++; $display("FAIL rst_de got=%0b exp=0", de); end
        if (px_x !== 10'd0) begin errors++; $display("FAIL rst_px_x got=%0d exp=0", px_x); end
        if (px_y !== 10'd0) begin errors++; $display("FAIL rst_px_y got=%0d exp=0", px_y); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs got=%0b exp=0", frame_start); end
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", err); end
    endtask

    task automatic test_loopback();
        int n_vf = 0;
        int n = 0;
        bit fs;
        do_reset(10, 7);
        clr_n = 1'b1;
        while (n_vf < 3 && n < 4 * HP * VL) begin
            tick();
            n++;
            fs = hist_fs[LAG-1];
            if (fs) n_vf++;
            checks++;
            if (err !== 1'b0) begin errors++; $display("FAIL loop_err got=%0b exp=0", err); end
            if (n_vf < 2) begin
                checks++;
                if (locked !== 1'b0 || frame_start !== 1'b0) begin
                    errors++;
                    $display("FAIL loop_prelock got=%0b/%0b exp=0/0 vf=%0d", locked, frame_start, n_vf);
                end
            end else begin
                checks += 4;
                if (locked !== 1'b1) begin errors++; $display("FAIL loop_locked got=%0b exp=1", locked); end
                if (frame_start !== fs) begin errors++; $display("FAIL loop_fs got=%0b exp=%0b", frame_start, fs); end
                if (hc !== 10'(hist_hc[LAG-1])) begin errors++; $display("FAIL loop_hc got=%0d exp=%0d", hc, hist_hc[LAG-1]); end
                if (vc !== 10'(hist_vc[LAG-1])) begin errors++; $display("FAIL loop_vc got=%0d exp=%0d", vc, hist_vc[LAG-1]); end
            end
        end
        checks++;
        if (n_vf < 3) begin errors++; $display("FAIL loop_timeout got=%0d exp=3 frames", n_vf); end
    endtask

    task automatic test_stretched_line();
        int n_vf = 0;
        int n = 0;
        bit seen_err = 0;
        bit st;
        bit exp_l;
        logic prev_locked;
        wait_pos(0, 5, "stretch");
        stretch_req = 1;
        prev_locked = locked;
        while (n_vf < 2 && n < 5 * HP * VL) begin
            tick();
            n++;
            st = hist_st[LAG-1];
            if (seen_err && hist_fs[LAG-1]) n_vf++;
            checks++;
            if (err !== st) begin errors++; $display("FAIL stretch_err got=%0b exp=%0b", err, st); end
            if (st) begin
                checks++;
                if (locked !== 1'b0 || prev_locked !== 1'b1) begin
                    errors++;
                    $display("FAIL stretch_drop got=%0b->%0b exp=1->0", prev_locked, locked);
                end
                seen_err = 1;
            end
            if (seen_err) begin
                exp_l = (n_vf >= 2);
                checks++;
                if (locked !== exp_l || frame_start !== exp_l) begin
                    errors++;
                    $display("FAIL stretch_relock got=%0b/%0b exp=%0b/%0b", locked, frame_start, exp_l, exp_l);
                end
            end
            prev_locked = locked;
        end
        checks++;
        if (n_vf < 2) begin errors++; $display("FAIL stretch_timeout got=%0d exp=2 frames", n_vf); end
    endtask

    task automatic test_hsync_stuck();
        int n = 0;
        bit got = 0;
        wait_pos(HPW + 2, 5, "stuck");
        hold_sync = 1;
        drive_sync();
        while (!got && n < 1200) begin
            tick();
            n++;
            if (err === 1'b1) begin
                got = 1;
                checks += 2;
                if (hc !== 10'd1023) begin errors++; $display("FAIL stuck_hc got=%0d exp=1023", hc); end
                if (locked !== 1'b0) begin errors++; $display("FAIL stuck_locked got=%0b exp=0", locked); end
            end else begin
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL stuck_prelock got=%0b exp=1", locked); end
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL stuck_timeout got=no err exp=err"); end
        repeat (10) begin
            tick();
            checks++;
            if (hc !== 10'd1023 || err !== 1'b0) begin
                errors++;
                $display("FAIL stuck_hold got=%0d/%0b exp=1023/0", hc, err);
            end
        end
        hold_sync = 0;
        drive_sync();
        got = 0;
        n = 0;
        while (!got && n < 2 * HP) begin
            tick();
            n++;
            if (hc === 10'd0) got = 1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL stuck_release got=%0d exp=0", hc); end
    endtask

    task automatic test_full_frame();
        int n = 0;
        int de_cnt = 0;
        int max_x = 0;
        int max_y = 0;
        bit first = 1;
        int f_x = -1;
        int f_y = -1;
        int f_hc = -1;
        int f_vc = -1;
        bit exp_de;
        int eh;
        int ev;
        do_reset(10, 7);
        clr_n = 1'b1;
        while (locked !== 1'b1 && n < 4 * HP * VL) begin
            tick();
            n++;
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL frame_lock got=%0b exp=1", locked); end
        repeat (HP * VL) begin
            tick();
            eh = hist_hc[LAG-1];
            ev = hist_vc[LAG-1];
            exp_de = (eh >= HB) && (eh < HF) && (ev >= VB) && (ev < VF);
            checks += 2;
            if (de !== exp_de) begin errors++; $display("FAIL frame_de got=%0b exp=%0b at %0d/%0d", de, exp_de, eh, ev); end
            if (exp_de) begin
                if (px_x !== 10'(eh - HB) || px_y !== 10'(ev - VB)) begin
                    errors++;
                    $display("FAIL frame_px got=%0d/%0d exp=%0d/%0d", px_x, px_y, eh - HB, ev - VB);
                end
            end else if (px_x !== 10'd0 || px_y !== 10'd0) begin
                errors++;
                $display("FAIL frame_px_idle got=%0d/%0d exp=0/0", px_x, px_y);
            end
            if (de === 1'b1) begin
                de_cnt++;
                if (int'(px_x) > max_x) max_x = int'(px_x);
                if (int'(px_y) > max_y) max_y = int'(px_y);
                if (first) begin
                    first = 0;
                    f_x = int'(px_x);
                    f_y = int'(px_y);
                    f_hc = int'(hc);
                    f_vc = int'(vc);
                end
            end
        end
        // Active window is 28 x 14 for this reduced timing.
        checks += 4;
        if (de_cnt != 392) begin errors++; $display("FAIL frame_de_count got=%0d exp=392", de_cnt); end
        if (max_x != 27 || max_y != 13) begin errors++; $display("FAIL frame_px_max got=%0d/%0d exp=27/13", max_x, max_y); end
        if (f_x != 0 || f_y != 0) begin errors++; $display("FAIL frame_first_px got=%0d/%0d exp=0/0", f_x, f_y); end
        if (f_hc != 8 || f_vc != 4) begin errors++; $display("FAIL frame_first_pos got=%0d/%0d exp=8/4", f_hc, f_vc); end
    endtask

    task automatic test_reset_midframe();
        int n_vf = 0;
        int n = 0;
        bit exp_l;
        wait_pos(10, 8, "midrst");
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%0b exp=1", locked); end
        clr_n = 1'b0;
        #1;
        checks += 4;
        if (hc !== 10'd0 || vc !== 10'd0) begin errors++; $display("FAIL midrst_cnt got=%0d/%0d exp=0/0", hc, vc); end
        if (locked !== 1'b0 || de !== 1'b0) begin errors++; $display("FAIL midrst_lock got=%0b/%0b exp=0/0", locked, de); end
        if (px_x !== 10'd0 || px_y !== 10'd0) begin errors++; $display("FAIL midrst_px got=%0d/%0d exp=0/0", px_x, px_y); end
        if (frame_start !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_pulse got=%0b/%0b exp=0/0", frame_start, err); end
        repeat (3) tick();
        clr_n = 1'b1;
        while (n_vf < 2 && n < 4 * HP * VL) begin
            tick();
            n++;
            if (hist_fs[LAG-1]) n_vf++;
            exp_l = (n_vf >= 2);
            checks += 2;
            if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got=%0b exp=0", err); end
            if (locked !== exp_l || frame_start !== exp_l) begin
                errors++;
                $display("FAIL midrst_relock got=%0b/%0b exp=%0b/%0b", locked, frame_start, exp_l, exp_l);
            end
        end
        checks++;
        if (n_vf < 2) begin errors++; $display("FAIL midrst_timeout got=%0d exp=2 frames", n_vf); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_stretched_line();
        test_hsync_stuck();
        test_full_frame();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
